// File: rtl/gbuf_read_scheduler.sv
// ============================================================================
//  Module   : gbuf_read_scheduler
//  Purpose  : Shares the global buffer's single asynchronous read port between
//             two burst requesters (0 = ifmap fetch, 1 = filter fetch) using
//             round-robin arbitration. Generates sequential read addresses and
//             returns registered data with a last-beat marker. Forwards the
//             psum writeback onto the buffer write port unchanged.
//
//  Ports    : clk, rst               clock / synchronous active-high reset
//             rq_req, rq*_base/len   burst requests (held until acked)
//             rq_ack                 one-hot acceptance pulse (combinational)
//             rd_valid/owner/data/last  registered read beat
//             wr_en/addr/data        writer input
//             mem_raddr/waddr/wen/din/dout  global buffer connections
//
//  Options  : GBUF_RAW_FORWARD_EN - when defined, a write hitting the address
//             being read in the same cycle is forwarded into rd_data, so a
//             beat always returns the newest value.
//
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gbuf_read_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            rq_req,
    input  logic [ADDR_WIDTH-1:0] rq0_base,
    input  logic [ADDR_WIDTH-1:0] rq1_base,
    input  logic [LEN_WIDTH-1:0]  rq0_len,
    input  logic [LEN_WIDTH-1:0]  rq1_len,
    output logic [1:0]            rq_ack,
    output logic                  rd_valid,
    output logic                  rd_owner,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_rr;        // requester favoured on a tie
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_beat_cnt;
    logic                  r_owner;
    logic                  r_rd_valid;
    logic                  r_rd_owner;
    logic                  r_rd_last;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_grant;
    logic                  w_winner;
    logic [ADDR_WIDTH-1:0] w_sel_base;
    logic [LEN_WIDTH-1:0]  w_sel_len;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic                  w_last_addr;
    logic                  w_wen;
    logic [DATA_WIDTH-1:0] w_capture;

    // ------------------------------------------------------------------
    // Arbitration: on a tie the requester not served last wins; a lone
    // requester always wins. Acks are suppressed while in reset.
    // ------------------------------------------------------------------
    assign w_grant    = (r_state == ST_IDLE) && (rq_req != 2'b00) && !rst;
    assign w_winner   = (rq_req == 2'b11) ? r_rr : rq_req[1];
    assign w_sel_base = w_winner ? rq1_base : rq0_base;
    assign w_sel_len  = w_winner ? rq1_len  : rq0_len;
    assign rq_ack     = w_grant ? (w_winner ? 2'b10 : 2'b01) : 2'b00;

    // Address arithmetic wraps naturally at the address width.
    assign w_raddr     = ((r_state == ST_BURST) && !rst)
                       ? (r_base + ADDR_WIDTH'(r_beat_cnt))
                       : '0;
    assign w_last_addr = (r_beat_cnt == (r_len - LEN_WIDTH'(1)));
    assign mem_raddr   = w_raddr;

    // Write path is a straight pass-through; writes never stall.
    assign w_wen     = wr_en & ~rst;
    assign mem_wen   = w_wen;
    assign mem_waddr = wr_addr;
    assign mem_din   = wr_data;

`ifdef GBUF_RAW_FORWARD_EN
    // The buffer returns pre-write contents on a same-cycle collision, so
    // the incoming write data is substituted to deliver the newest value.
    assign w_capture = (w_wen && (wr_addr == w_raddr)) ? wr_data : mem_dout;
`else
    assign w_capture = mem_dout;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rr       <= 1'b0;
            r_base     <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
            r_owner    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_owner <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_base     <= w_sel_base;
                        r_len      <= w_sel_len;
                        r_owner    <= w_winner;
                        r_rr       <= ~w_winner;
                        r_beat_cnt <= '0;
                        // Zero-length requests are acked and dropped.
                        if (w_sel_len != '0) begin
                            r_state <= ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    r_rd_valid <= 1'b1;
                    r_rd_data  <= w_capture;
                    r_rd_owner <= r_owner;
                    r_rd_last  <= w_last_addr;
                    if (w_last_addr) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_owner = r_rd_owner;
    assign rd_data  = r_rd_data;
    assign rd_last  = r_rd_last;

endmodule

`default_nettype wire

// File: tb/tb_gbuf_read_scheduler.sv
// ============================================================================
//  Module   : tb_gbuf_read_scheduler
//  Purpose  : Self-checking bench for gbuf_read_scheduler. Inputs are driven
//             on the falling edge and outputs sampled 1 ns later. A reference
//             buffer image plus a transaction-level arbitration model predict
//             acks and beats.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gbuf_read_scheduler;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int LW = 6;

    logic          clk;
    logic          rst;
    logic [1:0]    rq_req;
    logic [AW-1:0] rq0_base, rq1_base;
    logic [LW-1:0] rq0_len, rq1_len;
    logic [1:0]    rq_ack;
    logic          rd_valid, rd_owner, rd_last;
    logic [DW-1:0] rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic          mem_wen;
    logic [DW-1:0] mem_din, mem_dout;

    logic [DW-1:0] mem     [0:255];   // buffer storage driven by the DUT
    logic [DW-1:0] ref_mem [0:255];   // bench's own view of the contents

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          at;
        logic        owner;
        logic [DW-1:0] data;
        logic        last;
    } beat_t;

    gbuf_read_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .rq_req(rq_req),
        .rq0_base(rq0_base), .rq1_base(rq1_base),
        .rq0_len(rq0_len), .rq1_len(rq1_len),
        .rq_ack(rq_ack), .rd_valid(rd_valid), .rd_owner(rd_owner),
        .rd_data(rd_data), .rd_last(rd_last),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wen(mem_wen),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_dout = mem[mem_raddr];
    always @(posedge clk) if (mem_wen) mem[mem_waddr] <= mem_din;

    task automatic next_cycle();
        @(negedge clk);
        cyc = cyc + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rq_req = 2'b11; wr_en = 1'b1; wr_addr = 8'h05; wr_data = 16'h1234;
        for (int n = 0; n < 3; n++) begin
            next_cycle(); #1;
            checks++; if (rq_ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", rq_ack); end
            checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b want 0", mem_wen); end
        end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rd_valid); end
        checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", rd_last); end
        checks++; if (rd_owner !== 1'b0) begin errors++; $display("FAIL reset_owner: got %b want 0", rd_owner); end
        checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", rd_data); end
        checks++; if (mem_raddr !== 8'h00) begin errors++; $display("FAIL reset_raddr: got %h want 00", mem_raddr); end
        next_cycle();
        rst = 1'b0; rq_req = 2'b00; wr_en = 1'b0;
    endtask

    // Preloads mem[i] = i through the write port.
    task automatic test_write_path();
        for (int i = 0; i < 256; i++) begin
            next_cycle();
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(i);
            ref_mem[i] = DW'(i);
            #1;
            if (i % 64 == 7) begin
                checks++;
                if (mem_wen !== 1'b1 || mem_waddr !== AW'(i) || mem_din !== DW'(i)) begin
                    errors++;
                    $display("FAIL write_pass: got wen=%b addr=%h din=%h want 1 %h %h", mem_wen, mem_waddr, mem_din, AW'(i), DW'(i));
                end
            end
        end
        next_cycle(); wr_en = 1'b0; #1;
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL write_idle: got %b want 0", mem_wen); end
    endtask

    task automatic test_single_burst();
        next_cycle(); rq_req = 2'b01; rq0_base = 8'h10; rq0_len = 6'd4; #1;
        checks++; if (rq_ack !== 2'b01) begin errors++; $display("FAIL single_ack: got %b want 01", rq_ack); end
        next_cycle(); rq_req = 2'b00; #1;
        checks++; if (mem_raddr !== 8'h10) begin errors++; $display("FAIL single_addr: got %h want 10", mem_raddr); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", rd_valid); end
        for (int k = 0; k < 4; k++) begin
            next_cycle(); #1;
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== ref_mem[8'h10 + k] || rd_owner !== 1'b0 || rd_last !== (k == 3)) begin
                errors++;
                $display("FAIL single_beat%0d: got v=%b d=%h o=%b l=%b want 1 %h 0 %b", k, rd_valid, rd_data, rd_owner, rd_last, ref_mem[8'h10 + k], (k == 3));
            end
        end
        next_cycle(); #1;
        checks++; if (rd_valid !== 1'b0 || rd_last !== 1'b0) begin errors++; $display("FAIL single_end: got v=%b l=%b want 0 0", rd_valid, rd_last); end
    endtask

    task automatic test_contention();
        logic [1:0]    exp_ack;
        logic          ev, eo;
        int            s, idx;
        logic [AW-1:0] ea;
        next_cycle(); rst = 1'b1; #1;
        next_cycle(); rst = 1'b0; rq_req = 2'b11;
        rq0_base = 8'h20; rq0_len = 6'd2; rq1_base = 8'h40; rq1_len = 6'd2; #1;
        checks++; if (rq_ack !== 2'b01) begin errors++; $display("FAIL cont_ack0: got %b want 01", rq_ack); end
        for (int n = 1; n <= 15; n++) begin
            next_cycle();
            if (n == 1 || n == 9) rq_req = 2'b10;
            if (n == 4 || n == 12) rq_req = 2'b00;
            if (n == 8) rq_req = 2'b11;
            #1;
            exp_ack = (n == 8) ? 2'b01 : ((n == 3 || n == 11) ? 2'b10 : 2'b00);
            checks++; if (rq_ack !== exp_ack) begin errors++; $display("FAIL cont_ack n=%0d: got %b want %b", n, rq_ack, exp_ack); end
            s  = n % 8;
            ev = (n >= 2) && (s == 2 || s == 3 || s == 5 || s == 6);
            eo = (s >= 5);
            idx = eo ? s - 5 : s - 2;
            ea = eo ? 8'h40 : 8'h20;
            ea = ea + AW'(idx);
            checks++;
            if (rd_valid !== ev) begin
                errors++; $display("FAIL cont_valid n=%0d: got %b want %b", n, rd_valid, ev);
            end else if (ev && (rd_data !== ref_mem[ea] || rd_owner !== eo || rd_last !== (idx == 1))) begin
                errors++; $display("FAIL cont_beat n=%0d: got d=%h o=%b l=%b want %h %b %b", n, rd_data, rd_owner, rd_last, ref_mem[ea], eo, (idx == 1));
            end
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] ea;
        next_cycle(); rq_req = 2'b01; rq0_base = 8'hFE; rq0_len = 6'd4; #1;
        checks++; if (rq_ack !== 2'b01) begin errors++; $display("FAIL wrap_ack: got %b want 01", rq_ack); end
        for (int n = 1; n <= 6; n++) begin
            next_cycle();
            if (n == 1) rq_req = 2'b00;
            #1;
            ea = 8'hFE; ea = ea + AW'(n - 1);
            if (n <= 4) begin
                checks++; if (mem_raddr !== ea) begin errors++; $display("FAIL wrap_addr n=%0d: got %h want %h", n, mem_raddr, ea); end
            end else begin
                checks++; if (mem_raddr !== 8'h00) begin errors++; $display("FAIL wrap_idle_addr n=%0d: got %h want 00", n, mem_raddr); end
            end
            if (n >= 2 && n <= 5) begin
                ea = 8'hFE; ea = ea + AW'(n - 2);
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== ref_mem[ea] || rd_last !== (n == 5)) begin
                    errors++; $display("FAIL wrap_beat n=%0d: got v=%b d=%h l=%b want 1 %h %b", n, rd_valid, rd_data, rd_last, ref_mem[ea], (n == 5));
                end
            end
        end
    endtask

    task automatic test_zero_len();
        logic [1:0] exp_ack;
        logic       ev;
        next_cycle(); rq_req = 2'b10; rq1_base = 8'h33; rq1_len = 6'd0; #1;
        checks++; if (rq_ack !== 2'b10) begin errors++; $display("FAIL zero_ack: got %b want 10", rq_ack); end
        next_cycle(); rq_req = 2'b11; rq0_base = 8'h60; rq0_len = 6'd1; rq1_base = 8'h70; rq1_len = 6'd1; #1;
        checks++; if (rq_ack !== 2'b01) begin errors++; $display("FAIL zero_rr: got %b want 01", rq_ack); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL zero_no_beat: got %b want 0", rd_valid); end
        for (int n = 1; n <= 5; n++) begin
            next_cycle();
            if (n == 1) rq_req = 2'b10;
            if (n == 3) rq_req = 2'b00;
            #1;
            exp_ack = (n == 2) ? 2'b10 : 2'b00;
            checks++; if (rq_ack !== exp_ack) begin errors++; $display("FAIL zero_ack2 n=%0d: got %b want %b", n, rq_ack, exp_ack); end
            ev = (n == 2 || n == 4);
            checks++;
            if (rd_valid !== ev) begin
                errors++; $display("FAIL zero_valid n=%0d: got %b want %b", n, rd_valid, ev);
            end else if (ev && (rd_owner !== (n == 4) || rd_last !== 1'b1 || rd_data !== ref_mem[(n == 4) ? 8'h70 : 8'h60])) begin
                errors++; $display("FAIL zero_beat n=%0d: got d=%h o=%b l=%b", n, rd_data, rd_owner, rd_last);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [AW-1:0] ea;
        next_cycle(); rq_req = 2'b01; rq0_base = 8'h30; rq0_len = 6'd8; #1;
        checks++; if (rq_ack !== 2'b01) begin errors++; $display("FAIL rmb_ack: got %b want 01", rq_ack); end
        for (int n = 1; n <= 14; n++) begin
            next_cycle();
            if (n == 1) rq_req = 2'b00;
            rst = (n == 5);
            if (n == 8) begin rq_req = 2'b10; rq1_base = 8'h50; rq1_len = 6'd2; end
            if (n == 9) rq_req = 2'b00;
            #1;
            if (n >= 2 && n <= 5) begin
                ea = 8'h30; ea = ea + AW'(n - 2);
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== ref_mem[ea] || rd_last !== 1'b0) begin
                    errors++; $display("FAIL rmb_beat n=%0d: got v=%b d=%h l=%b want 1 %h 0", n, rd_valid, rd_data, rd_last, ref_mem[ea]);
                end
            end else if (n == 6 || n == 7 || n >= 12) begin
                checks++;
                if (rd_valid !== 1'b0 || (n <= 7 && mem_raddr !== 8'h00)) begin
                    errors++; $display("FAIL rmb_quiet n=%0d: got v=%b addr=%h want 0 00", n, rd_valid, mem_raddr);
                end
            end else if (n == 8) begin
                checks++; if (rq_ack !== 2'b10) begin errors++; $display("FAIL rmb_new_ack: got %b want 10", rq_ack); end
            end else if (n == 10 || n == 11) begin
                ea = 8'h50; ea = ea + AW'(n - 10);
                checks++;
                if (rd_valid !== 1'b1 || rd_owner !== 1'b1 || rd_data !== ref_mem[ea] || rd_last !== (n == 11)) begin
                    errors++; $display("FAIL rmb_new_beat n=%0d: got v=%b o=%b d=%h l=%b want 1 1 %h %b", n, rd_valid, rd_owner, rd_data, rd_last, ref_mem[ea], (n == 11));
                end
            end
        end
    endtask

    task automatic test_raw_collision();
        logic [DW-1:0] exp_d;
        logic [AW-1:0] ea;
        ref_mem[8'h11] = 16'hAAAA;
        next_cycle(); rq_req = 2'b01; rq0_base = 8'h10; rq0_len = 6'd4; #1;
        checks++; if (rq_ack !== 2'b01) begin errors++; $display("FAIL raw_ack: got %b want 01", rq_ack); end
        for (int n = 1; n <= 9; n++) begin
            next_cycle();
            if (n == 1 || n == 7) rq_req = 2'b00;
            if (n == 6) begin rq_req = 2'b01; rq0_base = 8'h11; rq0_len = 6'd1; end
            wr_en = (n == 2); wr_addr = 8'h11; wr_data = 16'hAAAA;
            #1;
            if (n == 2) begin
                checks++; if (mem_raddr !== 8'h11 || mem_wen !== 1'b1) begin errors++; $display("FAIL raw_setup: got addr=%h wen=%b want 11 1", mem_raddr, mem_wen); end
            end
            if (n >= 2 && n <= 5) begin
                ea = 8'h10; ea = ea + AW'(n - 2);
`ifdef GBUF_RAW_FORWARD_EN
                exp_d = (n == 3) ? 16'hAAAA : ref_mem[ea];
`else
                exp_d = (n == 3) ? 16'h0011 : ref_mem[ea];
`endif
                checks++; if (rd_valid !== 1'b1 || rd_data !== exp_d) begin errors++; $display("FAIL raw_beat n=%0d: got v=%b d=%h want 1 %h", n, rd_valid, rd_data, exp_d); end
            end
            if (n == 6) begin
                checks++; if (rq_ack !== 2'b01) begin errors++; $display("FAIL raw_reread_ack: got %b want 01", rq_ack); end
            end
            if (n == 8) begin
                checks++; if (rd_valid !== 1'b1 || rd_data !== 16'hAAAA || rd_last !== 1'b1) begin errors++; $display("FAIL raw_reread: got v=%b d=%h l=%b want 1 aaaa 1", rd_valid, rd_data, rd_last); end
            end
        end
        wr_en = 1'b0;
    endtask

    // Randomized traffic against a transaction-level model: a burst granted
    // at cycle c with length L occupies the port until c+1+L and returns its
    // beats at c+2 .. c+1+L; ties go to the requester not served last.
    task automatic test_random();
        beat_t         q[$];
        beat_t         bt;
        logic [1:0]    req, exp_ack;
        logic [AW-1:0] b [2];
        logic [LW-1:0] l [2];
        int            next_free, prio, w;
        next_cycle(); rst = 1'b1; rq_req = 2'b00; #1;
        next_cycle(); rst = 1'b0; #1;
        req = 2'b00; next_free = 0; prio = 0;
        for (int it = 0; it < 600; it++) begin
            next_cycle();
            for (int r = 0; r < 2; r++) begin
                if (!req[r] && it < 560 && $urandom_range(0, 2) == 0) begin
                    req[r] = 1'b1;
                    b[r]   = AW'($urandom);
                    l[r]   = LW'($urandom_range(0, 6));
                end
            end
            rq_req = req; rq0_base = b[0]; rq1_base = b[1]; rq0_len = l[0]; rq1_len = l[1];
            #1;
            exp_ack = 2'b00;
            if (cyc >= next_free && req != 2'b00) begin
                w = (req == 2'b11) ? prio : (req[1] ? 1 : 0);
                exp_ack[w] = 1'b1;
                prio = 1 - w;
                next_free = cyc + 1 + int'(l[w]);
                for (int i = 0; i < int'(l[w]); i++) begin
                    bt.at = cyc + 2 + i; bt.owner = w[0];
                    bt.data = ref_mem[AW'(int'(b[w]) + i)];
                    bt.last = (i == int'(l[w]) - 1);
                    q.push_back(bt);
                end
                req[w] = 1'b0;
            end
            checks++; if (rq_ack !== exp_ack) begin errors++; $display("FAIL rand_ack cyc=%0d: got %b want %b", cyc, rq_ack, exp_ack); end
            checks++;
            if (q.size() > 0 && q[0].at == cyc) begin
                bt = q.pop_front();
                if (rd_valid !== 1'b1 || rd_data !== bt.data || rd_owner !== bt.owner || rd_last !== bt.last) begin
                    errors++; $display("FAIL rand_beat cyc=%0d: got v=%b d=%h o=%b l=%b want 1 %h %b %b", cyc, rd_valid, rd_data, rd_owner, rd_last, bt.data, bt.owner, bt.last);
                end
            end else if (rd_valid !== 1'b0) begin
                errors++; $display("FAIL rand_spurious cyc=%0d: got v=1 want 0", cyc);
            end
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d beats outstanding want 0", q.size()); end
        rq_req = 2'b00;
    endtask

    initial begin
        rst = 1'b1; rq_req = 2'b00; rq0_base = '0; rq1_base = '0; rq0_len = '0; rq1_len = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        test_reset();
        test_write_path();
        test_single_burst();
        test_contention();
        test_wrap();
        test_zero_len();
        test_reset_mid_burst();
        test_raw_collision();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
